// File: rtl/cond_stage.sv
// ============================================================================
// cond_stage : condition-check pipeline stage with architectural flags,
//              valid/ready handshake and squashed-instruction counter.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module cond_stage #(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] Result,
   input  logic [3:0]       ALUFlags,
   input  logic [3:0]       Cond,
   input  logic [1:0]       FlagW,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             PCS,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] OutResult,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             PCSrc,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [15:0]      SquashCnt
);

   localparam logic [15:0] c_sq_max = 16'hFFFF;

   logic             out_valid_q, out_valid_d;
   logic [width-1:0] result_q, result_d;
   logic             reg_write_q, reg_write_d;
   logic             mem_write_q, mem_write_d;
   logic             pc_src_q, pc_src_d;
   logic             cond_ex_q, cond_ex_d;
   logic [3:0]       flags_q, flags_d;
   logic [15:0]      squash_cnt_q, squash_cnt_d;

   logic w_accept;
   logic w_cond_true;
   logic w_v, w_c, w_n, w_z;

   // Flags layout is {V,C,N,Z}; condition sees the value before this update.
   assign w_v = flags_q[3];
   assign w_c = flags_q[2];
   assign w_n = flags_q[1];
   assign w_z = flags_q[0];

   assign in_ready = ~out_valid_q | out_ready;
   assign w_accept = in_valid & in_ready;

   always_comb begin
      w_cond_true = 1'b0;
      unique case (Cond)
         4'b0000: w_cond_true = w_z;
         4'b0001: w_cond_true = ~w_z;
         4'b0010: w_cond_true = w_c;
         4'b0011: w_cond_true = ~w_c;
         4'b0100: w_cond_true = w_n;
         4'b0101: w_cond_true = ~w_n;
         4'b0110: w_cond_true = w_v;
         4'b0111: w_cond_true = ~w_v;
         4'b1000: w_cond_true = w_c & ~w_z;
         4'b1001: w_cond_true = ~w_c | w_z;
         4'b1010: w_cond_true = (w_n == w_v);
         4'b1011: w_cond_true = (w_n != w_v);
         4'b1100: w_cond_true = ~w_z & (w_n == w_v);
         4'b1101: w_cond_true = w_z | (w_n != w_v);
         4'b1110: w_cond_true = 1'b1;
         default: w_cond_true = 1'b0;
      endcase
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      result_d     = result_q;
      reg_write_d  = reg_write_q;
      mem_write_d  = mem_write_q;
      pc_src_d     = pc_src_q;
      cond_ex_d    = cond_ex_q;
      flags_d      = flags_q;
      squash_cnt_d = squash_cnt_q;

      if (w_accept) begin
         out_valid_d = 1'b1;
         result_d    = Result;
         cond_ex_d   = w_cond_true;
         reg_write_d = RegW & w_cond_true;
         mem_write_d = MemW & w_cond_true;
         pc_src_d    = PCS & w_cond_true;
         if (w_cond_true) begin
            if (FlagW[1]) flags_d[1:0] = ALUFlags[1:0];
            if (FlagW[0]) flags_d[3:2] = ALUFlags[3:2];
         end else if (squash_cnt_q != c_sq_max) begin
            squash_cnt_d = squash_cnt_q + 16'd1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         result_q     <= '0;
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         pc_src_q     <= 1'b0;
         cond_ex_q    <= 1'b0;
         flags_q      <= 4'b0000;
         squash_cnt_q <= 16'd0;
      end else begin
         out_valid_q  <= out_valid_d;
         result_q     <= result_d;
         reg_write_q  <= reg_write_d;
         mem_write_q  <= mem_write_d;
         pc_src_q     <= pc_src_d;
         cond_ex_q    <= cond_ex_d;
         flags_q      <= flags_d;
         squash_cnt_q <= squash_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign OutResult = result_q;
   assign RegWrite  = reg_write_q;
   assign MemWrite  = mem_write_q;
   assign PCSrc     = pc_src_q;
   assign CondEx    = cond_ex_q;
   assign Flags     = flags_q;
   assign SquashCnt = squash_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cond_stage.sv
// ============================================================================
// tb_cond_stage : directed self-checking bench for cond_stage.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_cond_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] Result;
   logic [3:0]  ALUFlags;
   logic [3:0]  Cond;
   logic [1:0]  FlagW;
   logic        RegW, MemW, PCS;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] OutResult;
   logic        RegWrite, MemWrite, PCSrc, CondEx;
   logic [3:0]  Flags;
   logic [15:0] SquashCnt;

   int total = 0;
   int bad   = 0;

   cond_stage #(.width(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .Result(Result), .ALUFlags(ALUFlags), .Cond(Cond), .FlagW(FlagW),
      .RegW(RegW), .MemW(MemW), .PCS(PCS), .out_valid(out_valid),
      .out_ready(out_ready), .OutResult(OutResult), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .PCSrc(PCSrc), .CondEx(CondEx), .Flags(Flags),
      .SquashCnt(SquashCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [3:0] c, input logic [1:0] fw,
                            input logic [3:0] af, input logic [31:0] res,
                            input logic rw, input logic mw, input logic ps);
      Cond = c; FlagW = fw; ALUFlags = af; Result = res;
      RegW = rw; MemW = mw; PCS = ps;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      set_instr(4'hE, 2'b11, 4'hF, 32'hDEAD, 1'b1, 1'b1, 1'b1);
      step(); step();
      in_valid = 1'b0; reset = 1'b0;
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (OutResult !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", OutResult); end
      total++; if ({CondEx, RegWrite, MemWrite, PCSrc} !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", {CondEx, RegWrite, MemWrite, PCSrc}); end
      total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
      total++; if (SquashCnt !== 16'd0) begin bad++; $display("FAIL reset_squash got=%0d exp=0", SquashCnt); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic();
      set_instr(4'hE, 2'b11, 4'b0001, 32'd5, 1'b1, 1'b0, 1'b0);
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      total++; if (OutResult !== 32'd5) begin bad++; $display("FAIL basic_result got=%0d exp=5", OutResult); end
      total++; if ({CondEx, RegWrite, MemWrite, PCSrc} !== 4'b1100) begin bad++; $display("FAIL basic_ctrl got=%b exp=1100", {CondEx, RegWrite, MemWrite, PCSrc}); end
      total++; if (Flags !== 4'b0001) begin bad++; $display("FAIL basic_flags got=%b exp=0001", Flags); end
   endtask

   task automatic test_squash();
      set_instr(4'h1, 2'b11, 4'b0100, 32'h77, 1'b1, 1'b1, 1'b1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL squash_valid got=%b exp=1", out_valid); end
      total++; if ({CondEx, RegWrite, MemWrite, PCSrc} !== 4'b0000) begin bad++; $display("FAIL squash_ctrl got=%b exp=0000", {CondEx, RegWrite, MemWrite, PCSrc}); end
      total++; if (Flags !== 4'b0001) begin bad++; $display("FAIL squash_flags got=%b exp=0001", Flags); end
      total++; if (SquashCnt !== 16'd1) begin bad++; $display("FAIL squash_cnt got=%0d exp=1", SquashCnt); end
      total++; if (OutResult !== 32'h77) begin bad++; $display("FAIL squash_result got=%h exp=77", OutResult); end
   endtask

   task automatic test_back_to_back();
      set_instr(4'hE, 2'b11, 4'b1000, 32'hA, 1'b0, 1'b1, 1'b0);
      in_valid = 1'b1;
      step();
      total++; if (OutResult !== 32'hA || MemWrite !== 1'b1) begin bad++; $display("FAIL b2b_a got=%h/%b exp=a/1", OutResult, MemWrite); end
      total++; if (Flags !== 4'b1000) begin bad++; $display("FAIL b2b_a_flags got=%b exp=1000", Flags); end
      set_instr(4'hB, 2'b00, 4'b0000, 32'hB, 1'b0, 1'b0, 1'b1);
      step();
      in_valid = 1'b0;
      total++; if ({CondEx, PCSrc} !== 2'b11) begin bad++; $display("FAIL b2b_b_cond got=%b exp=11", {CondEx, PCSrc}); end
      total++; if (OutResult !== 32'hB || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_b_result got=%h/%b exp=b/1", OutResult, out_valid); end
      total++; if (Flags !== 4'b1000 || SquashCnt !== 16'd1) begin bad++; $display("FAIL b2b_b_state got=%b/%0d exp=1000/1", Flags, SquashCnt); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_stall();
      set_instr(4'hE, 2'b00, 4'b0000, 32'hC, 1'b1, 1'b0, 1'b0);
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      set_instr(4'hE, 2'b11, 4'b0010, 32'hD, 1'b0, 1'b1, 1'b0);
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || OutResult !== 32'hC ||
             RegWrite !== 1'b1 || MemWrite !== 1'b0 || Flags !== 4'b1000) begin
            bad++;
            $display("FAIL stall_hold[%0d] got rdy=%b v=%b r=%h rw=%b mw=%b f=%b exp 0/1/c/1/0/1000",
                     i, in_ready, out_valid, OutResult, RegWrite, MemWrite, Flags);
         end
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      total++; if (OutResult !== 32'hD || MemWrite !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_next got=%h/%b/%b exp=d/1/1", OutResult, MemWrite, out_valid); end
      total++; if (Flags !== 4'b0010) begin bad++; $display("FAIL stall_flags got=%b exp=0010", Flags); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup got=%b exp=0", out_valid); end
   endtask

   // Flags = 0010 (N only): expected CondEx for Cond = 0..15.
   task automatic test_cond_table();
      logic [15:0] exp_tbl;
      exp_tbl = 16'b0110_1010_1001_1010;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
         set_instr(c[3:0], 2'b00, 4'b0101, 32'(c), 1'b1, 1'b0, 1'b0);
         step();
         total++;
         if (CondEx !== exp_tbl[c] || RegWrite !== exp_tbl[c]) begin
            bad++;
            $display("FAIL cond_%0d got=%b/%b exp=%b", c, CondEx, RegWrite, exp_tbl[c]);
         end
      end
      in_valid = 1'b0;
      total++; if (SquashCnt !== 16'd9 || Flags !== 4'b0010) begin bad++; $display("FAIL cond_tbl_state got=%0d/%b exp=9/0010", SquashCnt, Flags); end
   endtask

   task automatic test_nv_flagw();
      set_instr(4'hF, 2'b11, 4'b0101, 32'h1, 1'b1, 1'b0, 1'b0);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      total++; if (CondEx !== 1'b0 || Flags !== 4'b0010) begin bad++; $display("FAIL nv got=%b/%b exp=0/0010", CondEx, Flags); end
      total++; if (SquashCnt !== 16'd10) begin bad++; $display("FAIL nv_cnt got=%0d exp=10", SquashCnt); end
      reset = 1'b1; step(); reset = 1'b0;
      set_instr(4'hE, 2'b01, 4'b1111, 32'h2, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      total++; if (Flags !== 4'b1100) begin bad++; $display("FAIL flagw01 got=%b exp=1100", Flags); end
      set_instr(4'hE, 2'b11, 4'b0011, 32'h3, 1'b0, 1'b0, 1'b0);
      step(); step();
      total++; if (Flags !== 4'b1100 || SquashCnt !== 16'd0) begin bad++; $display("FAIL no_accept got=%b/%0d exp=1100/0", Flags, SquashCnt); end
   endtask

   task automatic test_reset_pending();
      set_instr(4'hE, 2'b11, 4'b0110, 32'h9, 1'b1, 1'b0, 1'b0);
      in_valid = 1'b1; out_ready = 1'b0;
      step();
      set_instr(4'hF, 2'b11, 4'b1111, 32'hA, 1'b1, 1'b0, 1'b0);
      out_ready = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0; in_valid = 1'b0;
      total++; if (out_valid !== 1'b0 || Flags !== 4'b0000 || SquashCnt !== 16'd0) begin bad++; $display("FAIL rst_pending got=%b/%b/%0d exp=0/0000/0", out_valid, Flags, SquashCnt); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_pending_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_saturate();
      set_instr(4'hF, 2'b00, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 65534; i++) step();
      total++; if (SquashCnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", SquashCnt); end
      step();
      total++; if (SquashCnt !== 16'hFFFF) begin bad++; $display("FAIL sat_max got=%h exp=ffff", SquashCnt); end
      step(); step();
      total++; if (SquashCnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", SquashCnt); end
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      set_instr(4'h0, 2'b00, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_basic();
      test_squash();
      test_back_to_back();
      test_stall();
      test_cond_table();
      test_nv_flagw();
      test_reset_pending();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
